mbinit_repairclk_tx: RTL and testbench
======================================

# mbinit_repairclk_tx

Transmit-side sequencer for the MBINIT.REPAIRCLK step: it drives the requests that the partner's REPAIRCLK receiver answers. It issues `init_req`, starts the clock-lane pattern generator, and requests the partner's logged per-lane results. On pass it closes the step with `done_req`; on fail or timeout it flags an error. It sits between the MBINIT controller (enable/end), the sideband encoder/decoder, and the repair-clock pattern generator.

## Interface
- SB_MSG_Width, 4, sideband message code width
- TIMEOUT_CYCLES, 8000, maximum cycles spent in any WAIT_* state before error
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_mbinit_repairclk_en  in  1  step enable from MBINIT controller; low forces IDLE
- i_sb_busy  in  1  sideband transmitter busy
- i_falling_edge_busy  in  1  one-cycle pulse: the sideband finished sending the current message
- i_decoded_sb_msg  in  SB_MSG_Width  received message code
- i_sb_valid  in  1  i_decoded_sb_msg is valid this cycle
- i_rx_logged_results  in  3  partner result payload {RTRK, RCKN, RCKP}, valid with result_resp
- i_pattern_done  in  1  pattern generator finished its burst (level or pulse)
- o_encoded_sb_msg  out  SB_MSG_Width  message code to send
- o_msg_valid  out  1  send request, held for the whole SEND state
- o_pattern_en  out  1  enable to the clock pattern generator
- o_logged_results  out  3  latched partner results
- o_TX_end  out  1  step completed successfully
- o_error  out  1  fail or timeout; held until enable drops

## Operation
- Message codes: init_req=1, init_resp=2, result_req=3, result_resp=4, done_req=5, done_resp=6.
- States and transitions (evaluated only while enabled; enable low → IDLE from any state):
  - IDLE → CHECK_BUSY_INIT.
  - CHECK_BUSY_x → SEND_x when !i_sb_busy.
  - SEND_INIT_REQ → WAIT_INIT_RESP on i_falling_edge_busy.
  - WAIT_INIT_RESP → SEND_PATTERN on valid init_resp.
  - SEND_PATTERN → CHECK_BUSY_RES on i_pattern_done.
  - SEND_RES_REQ → WAIT_RES_RESP on i_falling_edge_busy.
  - WAIT_RES_RESP on valid result_resp: latch i_rx_logged_results; go to CHECK_BUSY_DONE if the value is 3'b111, else to ERROR.
  - SEND_DONE_REQ → WAIT_DONE_RESP on i_falling_edge_busy.
  - WAIT_DONE_RESP → TX_END on valid done_resp.
  - TX_END and ERROR hold until enable drops.
- In WAIT states, valid messages with other codes are ignored (no state change).
- Timeout counter:
  - Clears on entry to each WAIT state and counts every cycle while in it.
  - When it reaches TIMEOUT_CYCLES-1 without the expected response → ERROR.
  - SEND_PATTERN is covered by the same counter.
  - If the expected message arrives in the same cycle as the terminal count, the message wins.
- Outputs are registered and decoded from the next state; every output defaults to 0 each cycle except o_logged_results.
  - SEND_INIT_REQ/SEND_RES_REQ/SEND_DONE_REQ: o_encoded_sb_msg = the matching req code and o_msg_valid=1.
  - SEND_PATTERN: o_pattern_en=1.
  - TX_END: o_TX_end=1.
  - ERROR: o_error=1.
- o_logged_results holds the latched value until IDLE is entered, then clears to 0.

## Timing
- Reset: state IDLE; all outputs 0.
- Enable rising in IDLE: CHECK_BUSY_INIT on the next edge. If the sideband is idle, o_msg_valid rises one edge later (outputs are registered from NS, so they align with the state register).
- Matching message with i_sb_valid in cycle N: the state and outputs change at edge N+1.
- o_msg_valid stays high through SEND_x and drops the cycle after i_falling_edge_busy.
- i_falling_edge_busy outside SEND states is ignored.
- Enable low in any state: state IDLE and outputs 0 at the next edge.
- i_rst mid-operation clears everything immediately (asynchronous).

## Structure
- A shared package (mbinit_pkg) holds:
  - the REPAIRCLK message-code localparams, shared with the receiver;
  - the state typedef;
  - the pass-pattern constant 3'b111.
- The timeout counter is a natural sub-module, mbinit_timeout_cnt, with clear/enable/expired ports and a width of $clog2(TIMEOUT_CYCLES); it is reusable by the other MBINIT steps.

## Test plan
- Nominal pass: enable, sideband idle, responses and i_pattern_done return promptly, result 3'b111 → codes 1, 3, 5 sent in order; o_TX_end=1; o_logged_results=3'b111; o_error=0.
- Lane fail: result_resp carries 3'b101 → no done_req is sent; o_error=1; o_logged_results=3'b101.
- Busy stall: i_sb_busy held for 20 cycles in CHECK_BUSY_INIT → o_msg_valid stays 0, then rises the cycle after busy drops.
- Timeout: TIMEOUT_CYCLES=16, init_resp never sent → o_error=1 after 16 cycles in WAIT_INIT_RESP; init_resp arriving on the terminal count → SEND_PATTERN instead.
- Abort: enable dropped during SEND_PATTERN, then during WAIT_RES_RESP → IDLE next edge with all outputs 0; re-enable restarts with init_req.
- Stray traffic: done_resp and result_resp received during WAIT_INIT_RESP → ignored; state unchanged.

Source files
------------

// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: REPAIRCLK sideband codes, TX sequencer states, result pattern.
// Pure declarations, no logic.
// No flow control here; the codes are common to the REPAIRCLK transmitter and receiver.
package mbinit_pkg;

    localparam int unsigned MSG_INIT_REQ    = 1;
    localparam int unsigned MSG_INIT_RESP   = 2;
    localparam int unsigned MSG_RESULT_REQ  = 3;
    localparam int unsigned MSG_RESULT_RESP = 4;
    localparam int unsigned MSG_DONE_REQ    = 5;
    localparam int unsigned MSG_DONE_RESP   = 6;

    localparam logic [2:0] REPAIRCLK_PASS = 3'b111;

    // Per-lane result payload as carried in result_resp.
    typedef struct packed {
        logic rtrk;
        logic rckn;
        logic rckp;
    } repairclk_res_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK_BUSY_INIT,
        ST_SEND_INIT_REQ,
        ST_WAIT_INIT_RESP,
        ST_SEND_PATTERN,
        ST_CHECK_BUSY_RES,
        ST_SEND_RES_REQ,
        ST_WAIT_RES_RESP,
        ST_CHECK_BUSY_DONE,
        ST_SEND_DONE_REQ,
        ST_WAIT_DONE_RESP,
        ST_TX_END,
        ST_ERROR
    } repairclk_tx_state_e;

endpackage

// File: rtl/mbinit_timeout_cnt.sv
// Timeout counter for MBINIT wait phases; flags once TIMEOUT_CYCLES-1 counts have elapsed.
// Latency: o_expired is combinational from the count register; clear takes effect at the next edge.
// No backpressure; counts every enabled cycle and saturates at the terminal count.
module mbinit_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 8000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_term;

    assign at_term   = (cnt_q == TERMINAL);
    assign o_expired = i_enable && at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && !at_term) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mbinit_repairclk_tx.sv
// MBINIT.REPAIRCLK transmit sequencer: init_req, clock pattern, result_req, done_req.
// Latency: outputs registered from next state, so they change on the same edge as the state.
// Backpressure: waits in CHECK_BUSY_* while the sideband is busy; bounded wait for every response.
module mbinit_repairclk_tx
    import mbinit_pkg::*;
#(
    parameter int unsigned SB_MSG_Width   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_mbinit_repairclk_en,
    input  logic                    i_sb_busy,
    input  logic                    i_falling_edge_busy,
    input  logic [SB_MSG_Width-1:0] i_decoded_sb_msg,
    input  logic                    i_sb_valid,
    input  logic [2:0]              i_rx_logged_results,
    input  logic                    i_pattern_done,
    output logic [SB_MSG_Width-1:0] o_encoded_sb_msg,
    output logic                    o_msg_valid,
    output logic                    o_pattern_en,
    output logic [2:0]              o_logged_results,
    output logic                    o_TX_end,
    output logic                    o_error
);

    repairclk_tx_state_e state_q, state_d;

    logic [SB_MSG_Width-1:0] msg_q, msg_d;
    logic                    msg_vld_q, msg_vld_d;
    logic                    pattern_en_q, pattern_en_d;
    logic                    tx_end_q, tx_end_d;
    logic                    error_q, error_d;
    repairclk_res_t          logged_q, logged_d;

    logic rx_init_resp;
    logic rx_res_resp;
    logic rx_done_resp;
    logic tmo_timed;
    logic tmo_clear;
    logic tmo_expired;

    assign rx_init_resp = i_sb_valid && (i_decoded_sb_msg == SB_MSG_Width'(MSG_INIT_RESP));
    assign rx_res_resp  = i_sb_valid && (i_decoded_sb_msg == SB_MSG_Width'(MSG_RESULT_RESP));
    assign rx_done_resp = i_sb_valid && (i_decoded_sb_msg == SB_MSG_Width'(MSG_DONE_RESP));

    // Every state change restarts the count, so each timed state gets a full budget.
    assign tmo_timed = (state_q == ST_WAIT_INIT_RESP) || (state_q == ST_SEND_PATTERN) ||
                       (state_q == ST_WAIT_RES_RESP)  || (state_q == ST_WAIT_DONE_RESP);
    assign tmo_clear = (state_d != state_q);

    mbinit_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (tmo_clear),
        .i_enable  (tmo_timed),
        .o_expired (tmo_expired)
    );

    always_comb begin
        state_d  = state_q;
        logged_d = logged_q;
        if (!i_mbinit_repairclk_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:            state_d = ST_CHECK_BUSY_INIT;
                ST_CHECK_BUSY_INIT: if (!i_sb_busy) state_d = ST_SEND_INIT_REQ;
                ST_SEND_INIT_REQ:   if (i_falling_edge_busy) state_d = ST_WAIT_INIT_RESP;
                ST_WAIT_INIT_RESP: begin
                    // The response takes priority over a simultaneous terminal count.
                    if (rx_init_resp)     state_d = ST_SEND_PATTERN;
                    else if (tmo_expired) state_d = ST_ERROR;
                end
                ST_SEND_PATTERN: begin
                    if (i_pattern_done)   state_d = ST_CHECK_BUSY_RES;
                    else if (tmo_expired) state_d = ST_ERROR;
                end
                ST_CHECK_BUSY_RES:  if (!i_sb_busy) state_d = ST_SEND_RES_REQ;
                ST_SEND_RES_REQ:    if (i_falling_edge_busy) state_d = ST_WAIT_RES_RESP;
                ST_WAIT_RES_RESP: begin
                    if (rx_res_resp) begin
                        logged_d = repairclk_res_t'(i_rx_logged_results);
                        state_d  = (i_rx_logged_results == REPAIRCLK_PASS) ?
                                   ST_CHECK_BUSY_DONE : ST_ERROR;
                    end else if (tmo_expired) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_CHECK_BUSY_DONE: if (!i_sb_busy) state_d = ST_SEND_DONE_REQ;
                ST_SEND_DONE_REQ:   if (i_falling_edge_busy) state_d = ST_WAIT_DONE_RESP;
                ST_WAIT_DONE_RESP: begin
                    if (rx_done_resp)     state_d = ST_TX_END;
                    else if (tmo_expired) state_d = ST_ERROR;
                end
                ST_TX_END:          state_d = ST_TX_END;
                ST_ERROR:           state_d = ST_ERROR;
                default:            state_d = ST_IDLE;
            endcase
        end
        if (state_d == ST_IDLE) begin
            logged_d = '0;
        end
    end

    always_comb begin
        msg_d        = '0;
        msg_vld_d    = 1'b0;
        pattern_en_d = 1'b0;
        tx_end_d     = 1'b0;
        error_d      = 1'b0;
        case (state_d)
            ST_SEND_INIT_REQ: begin
                msg_d     = SB_MSG_Width'(MSG_INIT_REQ);
                msg_vld_d = 1'b1;
            end
            ST_SEND_RES_REQ: begin
                msg_d     = SB_MSG_Width'(MSG_RESULT_REQ);
                msg_vld_d = 1'b1;
            end
            ST_SEND_DONE_REQ: begin
                msg_d     = SB_MSG_Width'(MSG_DONE_REQ);
                msg_vld_d = 1'b1;
            end
            ST_SEND_PATTERN: pattern_en_d = 1'b1;
            ST_TX_END:       tx_end_d     = 1'b1;
            ST_ERROR:        error_d      = 1'b1;
            default:         ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            msg_q        <= '0;
            msg_vld_q    <= 1'b0;
            pattern_en_q <= 1'b0;
            tx_end_q     <= 1'b0;
            error_q      <= 1'b0;
            logged_q     <= '0;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            msg_vld_q    <= msg_vld_d;
            pattern_en_q <= pattern_en_d;
            tx_end_q     <= tx_end_d;
            error_q      <= error_d;
            logged_q     <= logged_d;
        end
    end

    assign o_encoded_sb_msg = msg_q;
    assign o_msg_valid      = msg_vld_q;
    assign o_pattern_en     = pattern_en_q;
    assign o_TX_end         = tx_end_q;
    assign o_error          = error_q;
    assign o_logged_results = logged_q;

endmodule

// File: tb/tb_mbinit_repairclk_tx.sv
// Bench for mbinit_repairclk_tx: a sideband/partner model drives randomized handshakes and
// pushes the expected output events; a negedge monitor pops and compares them.
module tb_mbinit_repairclk_tx;

    localparam int TO    = 16;
    localparam int W     = 4;
    localparam int NEVER = 1000;

    localparam int C_INIT_REQ  = 1;
    localparam int C_INIT_RESP = 2;
    localparam int C_RES_REQ   = 3;
    localparam int C_RES_RESP  = 4;
    localparam int C_DONE_REQ  = 5;
    localparam int C_DONE_RESP = 6;

    localparam int K_MSG = 0;
    localparam int K_PAT = 1;
    localparam int K_END = 2;
    localparam int K_ERR = 3;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         en = 1'b0;
    logic         busy = 1'b0;
    logic         feb = 1'b0;
    logic [W-1:0] rx_msg = '0;
    logic         sb_vld = 1'b0;
    logic [2:0]   rx_res = '0;
    logic         pat_done = 1'b0;

    logic [W-1:0] o_msg;
    logic         o_vld;
    logic         o_pat;
    logic [2:0]   o_logged;
    logic         o_end;
    logic         o_err;

    mbinit_repairclk_tx #(
        .SB_MSG_Width   (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk                 (i_clk),
        .i_rst                 (i_rst),
        .i_mbinit_repairclk_en (en),
        .i_sb_busy             (busy),
        .i_falling_edge_busy   (feb),
        .i_decoded_sb_msg      (rx_msg),
        .i_sb_valid            (sb_vld),
        .i_rx_logged_results   (rx_res),
        .i_pattern_done        (pat_done),
        .o_encoded_sb_msg      (o_msg),
        .o_msg_valid           (o_vld),
        .o_pattern_en          (o_pat),
        .o_logged_results      (o_logged),
        .o_TX_end              (o_end),
        .o_error               (o_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int code;
        int rise;
        int fall;
        int val;
    } ev_t;

    ev_t sbq[$];
    int  total = 0;
    int  bad = 0;
    int  exp_logged = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(input int kind, input int code, input int rise,
                                 input int fall, input int val);
        ev_t e;
        e.kind = kind; e.code = code; e.rise = rise; e.fall = fall; e.val = val;
        sbq.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    logic pv_vld = 1'b0, pv_pat = 1'b0, pv_end = 1'b0, pv_err = 1'b0;
    int   fall_vld = -1;
    int   fall_pat = -1;
    int   fall_dummy;

    task automatic rise_ev(input int kind, input int code, input int val, output int fall);
        ev_t e;
        fall = -1;
        if (sbq.size() == 0) begin
            chk("unexpected_output_event", kind, -1);
            return;
        end
        e = sbq.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_rise_cycle", cyc, e.rise);
        if (kind == K_MSG) chk("msg_code", code, e.code);
        if (kind == K_END || kind == K_ERR) chk("logged_results_at_end", val, e.val);
        fall = e.fall;
    endtask

    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                pv_vld = 1'b0; pv_pat = 1'b0; pv_end = 1'b0; pv_err = 1'b0;
                fall_vld = -1; fall_pat = -1;
            end else begin
                if (o_vld && !pv_vld) rise_ev(K_MSG, int'(o_msg), 0, fall_vld);
                if (!o_vld && pv_vld && fall_vld >= 0) chk("msg_valid_fall_cycle", cyc, fall_vld);
                if (o_pat && !pv_pat) rise_ev(K_PAT, 0, 0, fall_pat);
                if (!o_pat && pv_pat && fall_pat >= 0) chk("pattern_en_fall_cycle", cyc, fall_pat);
                if (o_end && !pv_end) rise_ev(K_END, 0, int'(o_logged), fall_dummy);
                if (o_err && !pv_err) rise_ev(K_ERR, 0, int'(o_logged), fall_dummy);
                pv_vld = o_vld; pv_pat = o_pat; pv_end = o_end; pv_err = o_err;
            end
        end
    end

    // ---------------- sideband / partner model ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
        sb_vld   = 1'b0;
        feb      = 1'b0;
        pat_done = 1'b0;
        rx_msg   = '0;
    endtask

    // Called in the cycle whose trigger moves the DUT into CHECK_BUSY_x.
    task automatic do_send(input int code, input int stall, output int p);
        int s;
        int m;
        s = $urandom_range(1, 4);
        m = cyc + 2 + stall;
        push(K_MSG, code, m, m + s + 1, 0);
        if (stall > 0) busy = 1'b1;
        repeat (stall + 1) tick();
        busy = 1'b0;
        tick();
        busy = 1'b1;
        repeat (s) tick();
        busy = 1'b0;
        feb = 1'b1;
        p = cyc;
    endtask

    // Response arrives d cycles after WAIT entry; d >= TO means it never comes.
    task automatic do_wait(input int code, input int p, input int d, input bit stray, output int r);
        int v;
        if (d >= TO) push(K_ERR, 0, p + 1 + TO, -1, exp_logged);
        tick();
        for (int k = 0; k < d && k < TO + 2; k++) begin
            if (stray && $urandom_range(0, 1) == 1) begin
                v = $urandom_range(0, 15);
                while (v == code) v = $urandom_range(0, 15);
                sb_vld = 1'b1;
                rx_msg = W'(v);
                rx_res = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) feb = 1'b1;
            tick();
        end
        if (d < TO) begin
            sb_vld = 1'b1;
            rx_msg = W'(code);
            r = cyc;
        end else begin
            r = -1;
        end
    endtask

    task automatic finish_scen();
        en   = 1'b0;
        busy = 1'b0;
        tick();
        chk("outputs_zero_after_disable",
            int'({o_msg, o_vld, o_pat, o_logged, o_end, o_err}), 0);
        tick();
        tick();
        chk("scoreboard_drained", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic run_scen(input int stall_i, input int d_init, input bit stray, input int dp,
                            input int abort, input int dres, input int res, input int dd);
        int p;
        int r;
        int k;
        exp_logged = 0;
        en = 1'b1;
        do_send(C_INIT_REQ, stall_i, p);
        do_wait(C_INIT_RESP, p, d_init, stray, r);
        if (r < 0) begin finish_scen(); return; end
        if (abort == 1) begin
            k = $urandom_range(0, 5);
            push(K_PAT, 0, r + 1, r + 2 + k, 0);
            repeat (1 + k) tick();
            finish_scen();
            return;
        end
        if (dp >= TO) begin
            push(K_PAT, 0, r + 1, r + 1 + TO, 0);
            push(K_ERR, 0, r + 1 + TO, -1, exp_logged);
            repeat (TO + 3) tick();
            finish_scen();
            return;
        end
        push(K_PAT, 0, r + 1, r + 2 + dp, 0);
        repeat (1 + dp) tick();
        pat_done = 1'b1;
        do_send(C_RES_REQ, $urandom_range(0, 3), p);
        if (abort == 2) begin
            k = $urandom_range(0, 5);
            repeat (1 + k) tick();
            finish_scen();
            return;
        end
        do_wait(C_RES_RESP, p, dres, stray, r);
        if (r < 0) begin finish_scen(); return; end
        rx_res = 3'(res);
        if (res != 7) begin
            exp_logged = res;
            push(K_ERR, 0, r + 1, -1, res);
            repeat (3) tick();
            finish_scen();
            return;
        end
        exp_logged = 7;
        do_send(C_DONE_REQ, $urandom_range(0, 3), p);
        do_wait(C_DONE_RESP, p, dd, stray, r);
        if (r >= 0) begin
            push(K_END, 0, r + 1, -1, 7);
            repeat (3) tick();
        end
        finish_scen();
    endtask

    function automatic int pick_d();
        int c;
        c = $urandom_range(0, 9);
        if (c <= 6) return $urandom_range(0, 3);
        if (c == 7) return TO - 1;
        if (c == 8) return NEVER;
        return $urandom_range(4, 10);
    endfunction

    function automatic int pick_stall();
        return ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        #1 i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_outputs_zero", int'({o_msg, o_vld, o_pat, o_logged, o_end, o_err}), 0);
        i_rst = 1'b0;
        tick();
        tick();

        // directed cases
        run_scen(0, 0, 1'b0, 0, 0, 0, 7, 0);             // nominal pass
        run_scen(0, 1, 1'b0, 2, 0, 1, 5, 0);             // lane fail 3'b101
        run_scen(20, 0, 1'b0, 0, 0, 0, 7, 0);            // busy stall 20 cycles
        run_scen(0, NEVER, 1'b0, 0, 0, 0, 7, 0);         // init_resp timeout
        run_scen(0, TO - 1, 1'b0, 0, 0, 0, 7, 0);        // init_resp on terminal count
        run_scen(1, 0, 1'b0, 0, 1, 0, 7, 0);             // abort in SEND_PATTERN
        run_scen(0, 2, 1'b0, 1, 2, 0, 7, 0);             // abort in WAIT_RES_RESP
        run_scen(1, 6, 1'b1, 1, 0, 3, 7, 2);             // stray traffic in waits
        run_scen(0, 0, 1'b0, NEVER, 0, 0, 7, 0);         // pattern timeout
        run_scen(0, 0, 1'b0, TO - 1, 0, 0, 7, 0);        // pattern_done on terminal count
        run_scen(2, 0, 1'b0, 0, 0, NEVER, 7, 0);         // result_resp timeout
        run_scen(0, 0, 1'b0, 0, 0, 0, 7, NEVER);         // done_resp timeout
        run_scen(0, 0, 1'b0, 0, 0, TO - 1, 7, TO - 1);   // terminal count on res and done

        for (int i = 0; i < 30; i++) begin
            run_scen(pick_stall(), pick_d(), 1'($urandom_range(0, 1)), pick_d(),
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0,
                     pick_d(), ($urandom_range(0, 1) == 1) ? 7 : int'($urandom_range(0, 7)),
                     pick_d());
        end

        // asynchronous reset while init_req is being sent
        t0 = cyc;
        en = 1'b1;
        push(K_MSG, C_INIT_REQ, t0 + 2, -1, 0);
        tick();
        tick();
        @(negedge i_clk);
        #1 i_rst = 1'b1;
        #1;
        chk("async_reset_clears_outputs", int'({o_msg, o_vld, o_pat, o_logged, o_end, o_err}), 0);
        en = 1'b0;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        tick();
        chk("scoreboard_drained_after_reset", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
